// File: rtl/pll_apb_pkg.sv
// Shared encodings, FSM state type and defaults for the GPLL APB configuration block.
package pll_apb_pkg;

  // Command opcodes as presented on cmd_op.
  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_APPLY = 2'b10,
    OP_RSVD  = 2'b11
  } cmd_op_e;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SETUP     = 3'd1,
    ST_ACCESS    = 3'd2,
    ST_RST_PULSE = 3'd3,
    ST_WAIT_LOCK = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  // Number of consecutive high synchronised lock samples that count as locked.
  localparam int LOCK_STABLE_CNT = 8;

  // Parameter defaults.
  localparam int RST_CYCLES_DEF   = 16;
  localparam int LOCK_TIMEOUT_DEF = 65535;
  localparam int APB_TIMEOUT_DEF  = 255;

  // Counter widths: the cycle counter must hold LOCK_TIMEOUT, the stable counter 8.
  localparam int CNT_W = 16;
  localparam int STB_W = 4;

  // Saturating increment of the cycle counter; it sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser bringing the asynchronous GPLL LOCK into the apb_clk domain.
module pll_lock_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic lock_i,
  output logic lock_sync_o
);

  logic meta_q;
  logic sync_q;

  // Shift the raw lock through two flops; the first may go metastable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= lock_i;
      sync_q <= meta_q;
    end
  end

  assign lock_sync_o = sync_q;

endmodule

// File: rtl/pll_apb_cfg.sv
// GPLL configuration sequencer: turns WRITE/READ commands into APB transfers and
// APPLY commands into a PLL reset pulse followed by a bounded wait for stable lock.
module pll_apb_cfg
  import pll_apb_pkg::*;
#(
  parameter int RST_CYCLES   = RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int APB_TIMEOUT  = APB_TIMEOUT_DEF
) (
  input  logic        apb_clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [4:0]  cmd_addr,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        apb_rst_n,
  output logic        apb_sel,
  output logic        apb_en,
  output logic        apb_write,
  output logic [4:0]  apb_addr,
  output logic [15:0] apb_wdata,
  input  logic [15:0] apb_rdata,
  input  logic        apb_ready,
  output logic        pll_rst,
  input  logic        lock
);

  // Terminal counts: a state that must last N cycles leaves when the counter reads N-1.
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] APB_LAST    = CNT_W'(APB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STABLE_LAST = STB_W'(LOCK_STABLE_CNT - 1);

  state_e            state_q;
  cmd_op_e           op_q;
  logic [CNT_W-1:0]  cyc_cnt_q;
  logic [CNT_W-1:0]  cyc_cnt_d;
  logic [STB_W-1:0]  stb_cnt_q;
  logic [STB_W-1:0]  stb_cnt_d;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic [15:0]       rsp_rdata_q;
  logic              busy_q;
  logic              apb_rst_n_q;
  logic              apb_sel_q;
  logic              apb_en_q;
  logic              apb_write_q;
  logic [4:0]        apb_addr_q;
  logic [15:0]       apb_wdata_q;
  logic              pll_rst_q;
  logic              lock_s;

  pll_lock_sync u_lock_sync (
    .clk_i       (apb_clk),
    .rst_i       (rst),
    .lock_i      (lock),
    .lock_sync_o (lock_s)
  );

  // Saturating next values for both counters.
  always_comb begin
    cyc_cnt_d = cnt_sat_inc(cyc_cnt_q);
    if (stb_cnt_q == {STB_W{1'b1}}) begin
      stb_cnt_d = stb_cnt_q;
    end else begin
      stb_cnt_d = stb_cnt_q + STB_W'(1);
    end
  end

  // Sequencer with all outputs registered alongside the state; counters clear on every entry.
  always_ff @(posedge apb_clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_WRITE;
      cyc_cnt_q   <= '0;
      stb_cnt_q   <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 16'h0000;
      busy_q      <= 1'b0;
      apb_rst_n_q <= 1'b0;
      apb_sel_q   <= 1'b0;
      apb_en_q    <= 1'b0;
      apb_write_q <= 1'b0;
      apb_addr_q  <= 5'd0;
      apb_wdata_q <= 16'h0000;
      pll_rst_q   <= 1'b0;
    end else begin
      apb_rst_n_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            op_q        <= cmd_op_e'(cmd_op);
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            cyc_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            case (cmd_op_e'(cmd_op))
              OP_WRITE, OP_READ: begin
                state_q     <= ST_SETUP;
                apb_sel_q   <= 1'b1;
                apb_en_q    <= 1'b0;
                apb_addr_q  <= cmd_addr;
                apb_wdata_q <= cmd_wdata;
                apb_write_q <= (cmd_op == OP_WRITE);
              end
              OP_APPLY: begin
                state_q   <= ST_RST_PULSE;
                pll_rst_q <= 1'b1;
              end
              default: begin
                state_q     <= ST_RESP;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
              end
            endcase
          end
        end
        ST_SETUP: begin
          state_q   <= ST_ACCESS;
          apb_en_q  <= 1'b1;
          cyc_cnt_q <= '0;
        end
        ST_ACCESS: begin
          if (apb_ready) begin
            state_q     <= ST_RESP;
            apb_sel_q   <= 1'b0;
            apb_en_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            cyc_cnt_q   <= '0;
            if (op_q == OP_READ) begin
              rsp_rdata_q <= apb_rdata;
            end
          end else if (cyc_cnt_q >= APB_LAST) begin
            // Slave never answered: abandon the transfer and report it.
            state_q     <= ST_RESP;
            apb_sel_q   <= 1'b0;
            apb_en_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            cyc_cnt_q   <= '0;
          end else begin
            cyc_cnt_q <= cyc_cnt_d;
          end
        end
        ST_RST_PULSE: begin
          if (cyc_cnt_q >= RST_LAST) begin
            state_q   <= ST_WAIT_LOCK;
            pll_rst_q <= 1'b0;
            cyc_cnt_q <= '0;
            stb_cnt_q <= '0;
          end else begin
            cyc_cnt_q <= cyc_cnt_d;
          end
        end
        ST_WAIT_LOCK: begin
          // A stable lock on the very last allowed cycle still counts as success.
          if (lock_s && (stb_cnt_q >= STABLE_LAST)) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            cyc_cnt_q   <= '0;
            stb_cnt_q   <= '0;
          end else if (cyc_cnt_q >= LOCK_LAST) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            cyc_cnt_q   <= '0;
            stb_cnt_q   <= '0;
          end else begin
            cyc_cnt_q <= cyc_cnt_d;
            stb_cnt_q <= lock_s ? stb_cnt_d : '0;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          cyc_cnt_q   <= '0;
          stb_cnt_q   <= '0;
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          apb_sel_q   <= 1'b0;
          apb_en_q    <= 1'b0;
          pll_rst_q   <= 1'b0;
          cyc_cnt_q   <= '0;
          stb_cnt_q   <= '0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = busy_q;
  assign apb_rst_n = apb_rst_n_q;
  assign apb_sel   = apb_sel_q;
  assign apb_en    = apb_en_q;
  assign apb_write = apb_write_q;
  assign apb_addr  = apb_addr_q;
  assign apb_wdata = apb_wdata_q;
  assign pll_rst   = pll_rst_q;

endmodule

// File: tb/tb_pll_apb_cfg.sv
// Self-checking bench for pll_apb_cfg: directed corner cases plus random commands
// scored against a transaction-level reference model.
module tb_pll_apb_cfg;

  localparam int RST_CYC = 16;
  localparam int APB_TO  = 255;
  localparam int LOCK_TO = 1000;

  logic        apb_clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [4:0]  cmd_addr = 5'd0;
  logic [15:0] cmd_wdata = 16'h0000;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        apb_rst_n;
  logic        apb_sel;
  logic        apb_en;
  logic        apb_write;
  logic [4:0]  apb_addr;
  logic [15:0] apb_wdata;
  logic [15:0] apb_rdata = 16'h0000;
  logic        apb_ready = 1'b0;
  logic        pll_rst;
  logic        lock = 1'b0;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [15:0] rdata_model = 16'h0000;

  pll_apb_cfg #(
    .RST_CYCLES   (RST_CYC),
    .LOCK_TIMEOUT (LOCK_TO),
    .APB_TIMEOUT  (APB_TO)
  ) dut (
    .apb_clk   (apb_clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .apb_rst_n (apb_rst_n),
    .apb_sel   (apb_sel),
    .apb_en    (apb_en),
    .apb_write (apb_write),
    .apb_addr  (apb_addr),
    .apb_wdata (apb_wdata),
    .apb_rdata (apb_rdata),
    .apb_ready (apb_ready),
    .pll_rst   (pll_rst),
    .lock      (lock)
  );

  always #5 apb_clk = ~apb_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lock waveform seen by the PLL, indexed by cycles since pll_rst fell.
  function automatic bit lock_pat(input int j, input int rise, input int glitch);
    return (j >= rise) && (j != glitch);
  endfunction

  // One command end to end: drive it, act as APB slave / PLL, measure phases, compare to model.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] addr, input logic [15:0] wdata,
                         input int d, input logic [15:0] rdata, input int rise, input int glitch,
                         input bit junk);
    int setup_n = 0, access_n = 0, rst_n = 0, wait_n = 0, budget = 3000;
    bit stab_bad = 0, sel_bad = 0, ready_bad = 0, busy_bad = 0;
    int exp_setup = 0, exp_access = 0, exp_rst = 0, exp_wait = 0;
    bit exp_err = 0;
    logic [15:0] exp_rdata;
    int run = 0;
    bit done = 0;
    bit s;

    // Reference model, straight from the command rules.
    exp_rdata = rdata_model;
    if (op == 2'b00 || op == 2'b01) begin
      exp_setup  = 1;
      exp_err    = (d >= APB_TO);
      exp_access = exp_err ? APB_TO : d + 1;
      if (op == 2'b01 && !exp_err) exp_rdata = rdata;
    end else if (op == 2'b10) begin
      exp_rst = RST_CYC;
      // The PLL's lock value reaches the sequencer two cycles late through the synchroniser.
      for (int j = 0; j < LOCK_TO && !done; j++) begin
        s = (j >= 2) ? lock_pat(j - 2, rise, glitch) : 1'b0;
        run = s ? run + 1 : 0;
        if (run == 8) begin
          done = 1;
          exp_wait = j + 1;
        end
      end
      if (!done) exp_wait = LOCK_TO;
      exp_err = !done;
    end else begin
      exp_err = 1;
    end

    @(negedge apb_clk);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    @(negedge apb_clk);
    if (junk) begin
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_addr  = 5'($urandom);
      cmd_wdata = 16'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end

    while (!rsp_valid && budget > 0) begin
      if (cmd_ready) ready_bad = 1;
      if (!busy) busy_bad = 1;
      if (apb_sel && op[1]) sel_bad = 1;
      if (apb_sel && (apb_addr !== addr || apb_write !== (op == 2'b00) || apb_wdata !== wdata))
        stab_bad = 1;
      if (apb_sel && !apb_en) setup_n++;
      if (apb_sel && apb_en) begin
        apb_ready = (access_n == d);
        apb_rdata = rdata;
        access_n++;
      end else begin
        apb_ready = 1'b0;
      end
      if (pll_rst) begin
        rst_n++;
      end else if (rst_n > 0) begin
        lock = lock_pat(wait_n, rise, glitch);
        wait_n++;
      end
      budget--;
      @(negedge apb_clk);
    end
    chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    chk("rsp_busy", {31'd0, busy}, 32'd1);
    cmd_valid = 1'b0;
    apb_ready = 1'b0;
    lock      = 1'b0;

    chk("setup_cycles", setup_n, exp_setup);
    chk("access_cycles", access_n, exp_access);
    chk("pll_rst_cycles", rst_n, exp_rst);
    chk("wait_lock_cycles", wait_n, exp_wait);
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, exp_rdata});
    chk("addr_stable", {31'd0, stab_bad}, 32'd0);
    chk("sel_only_apb", {31'd0, sel_bad}, 32'd0);
    chk("no_accept_busy", {31'd0, ready_bad}, 32'd0);
    chk("busy_held", {31'd0, busy_bad}, 32'd0);
    rdata_model = exp_rdata;

    @(negedge apb_clk);
    chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
    chk("post_sel_en", {30'd0, apb_sel, apb_en}, 32'd0);
    chk("post_busy", {31'd0, busy}, 32'd0);
    chk("post_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int op, d, rise, glitch;

    // Reset state.
    repeat (3) @(negedge apb_clk);
    chk("rst_apb_rst_n", {31'd0, apb_rst_n}, 32'd0);
    chk("rst_sel_en", {30'd0, apb_sel, apb_en}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy_pllrst", {30'd0, busy, pll_rst}, 32'd0);
    rst = 1'b0;
    @(negedge apb_clk);
    chk("rel_apb_rst_n", {31'd0, apb_rst_n}, 32'd1);
    chk("rel_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rel_rsp", {14'd0, rsp_rdata, rsp_err}, 32'd0);
    chk("rel_apb_bus", {10'd0, apb_addr, apb_wdata, apb_write}, 32'd0);

    // Directed corners.
    run_cmd(2'b00, 5'h05, 16'h1234, 0, 16'h0000, 0, -1, 0);
    run_cmd(2'b01, 5'h1F, 16'h0000, 3, 16'hBEEF, 0, -1, 1);
    run_cmd(2'b01, 5'h0A, 16'h0000, APB_TO, 16'h5555, 0, -1, 0);
    run_cmd(2'b10, 5'h00, 16'h0000, 0, 16'h0000, 100, 104, 1);
    run_cmd(2'b10, 5'h00, 16'h0000, 0, 16'h0000, 100000, -1, 0);
    run_cmd(2'b11, 5'h07, 16'hAAAA, 0, 16'h0000, 0, -1, 0);

    // Reset in the middle of an access.
    @(negedge apb_clk);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 5'h03;
    @(negedge apb_clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge apb_clk);
    chk("mid_access_en", {31'd0, apb_en}, 32'd1);
    rst = 1'b1;
    @(negedge apb_clk);
    chk("abort_sel_en", {30'd0, apb_sel, apb_en}, 32'd0);
    chk("abort_idle", {29'd0, busy, rsp_valid, cmd_ready}, 32'd1);
    chk("abort_apb_rst_n", {31'd0, apb_rst_n}, 32'd0);
    @(negedge apb_clk);
    rst = 1'b0;
    chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge apb_clk);
    chk("abort_rel_rsp", {31'd0, rsp_valid}, 32'd0);
    rdata_model = 16'h0000;

    // Random commands.
    for (int i = 0; i < 30; i++) begin
      op     = $urandom_range(0, 3);
      d      = ($urandom_range(0, 7) == 0) ? 300 : $urandom_range(0, 6);
      rise   = ($urandom_range(0, 7) == 0) ? 5000 : $urandom_range(0, 40);
      glitch = ($urandom_range(0, 1) == 1) ? rise + $urandom_range(0, 10) : -1;
      run_cmd(2'(op), 5'($urandom), 16'($urandom), d, 16'($urandom), rise, glitch,
              1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_apb_cfg.md
PLL_APB_CFG -- requirements
Module: pll_apb_cfg

Interface
REQ-001 Parameter RST_CYCLES, default 16: PLL reset pulse width in apb_clk cycles, legal range 4..255.
REQ-002 Parameter LOCK_TIMEOUT, default 65535: maximum number of cycles waited for lock after the reset pulse.
REQ-003 Parameter APB_TIMEOUT, default 255: maximum number of ACCESS cycles waited for apb_ready.
REQ-004 apb_clk  in  1  the only clock; apb_clk drives all logic.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 cmd_valid/cmd_ready  in/out  1/1  command handshake; a transfer occurs when both are high on a rising edge.
REQ-007 cmd_op  in  2  command opcode: 00 = WRITE, 01 = READ, 10 = APPLY, 11 = reserved.
REQ-008 cmd_addr  in  5  GPLL register address; cmd_wdata  in  16  write data.
REQ-009 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  16  read data; rsp_err  out  1  error flag.
REQ-010 busy  out  1  high from command accept until rsp_valid is high.
REQ-011 apb_rst_n, apb_sel, apb_en, apb_write  out  1 each; apb_addr  out  5; apb_wdata  out  16.
REQ-012 apb_rdata  in  16; apb_ready  in  1.
REQ-013 pll_rst  out  1  drives the GPLL RST pin; lock  in  1  GPLL LOCK, asynchronous to apb_clk.

Function
REQ-014 FSM states: IDLE, SETUP, ACCESS, RST_PULSE, WAIT_LOCK, RESP.
REQ-015 cmd_ready SHALL be high only in IDLE; on accept, the command fields SHALL be registered.
REQ-016 Transitions on accept: WRITE/READ -> SETUP; APPLY -> RST_PULSE; reserved opcode -> RESP with rsp_err=1.
REQ-017 SETUP SHALL last exactly 1 cycle with apb_sel=1 and apb_en=0; apb_addr, apb_write and apb_wdata SHALL hold stable from SETUP through the end of ACCESS.
REQ-018 ACCESS SHALL drive apb_sel=1 and apb_en=1 until apb_ready=1, then go to RESP; READ SHALL capture apb_rdata in that same cycle.
REQ-019 In ACCESS, if apb_ready is not seen within APB_TIMEOUT cycles, the FSM SHALL drop sel/en and go to RESP with rsp_err=1.
REQ-020 RST_PULSE SHALL hold pll_rst=1 for exactly RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-021 WAIT_LOCK SHALL go to RESP with rsp_err=0 once the synchronised lock has been high for 8 consecutive cycles; a low sample SHALL restart the count.
REQ-022 WAIT_LOCK SHALL go to RESP with rsp_err=1 if LOCK_TIMEOUT cycles elapse first.
REQ-023 RESP SHALL last 1 cycle with rsp_valid=1, then return to IDLE.
REQ-024 rsp_rdata SHALL hold its last captured value until the next READ; WRITE and APPLY SHALL leave it unchanged.
REQ-025 apb_sel and apb_en SHALL be 0 in every state except SETUP and ACCESS.
REQ-026 Commands presented while busy SHALL NOT be accepted, and cmd_valid SHALL have no effect on state.
REQ-027 lock SHALL pass through a 2-flop synchroniser before any use.
REQ-028 Both counters SHALL saturate, never wrap, and SHALL clear on every state entry.

Reset
REQ-029 When rst=1, the state SHALL go to IDLE on the next edge, including mid-operation.
REQ-030 Reset values: cmd_ready=1 after release, rsp_valid=0, rsp_err=0, rsp_rdata=0, busy=0, apb_sel=0, apb_en=0, apb_write=0, apb_addr=0, apb_wdata=0, pll_rst=0, counters=0.
REQ-031 apb_rst_n SHALL be the registered inverse of rst: low during reset, high 1 cycle after release.
REQ-032 A reset during an access SHALL abort it with no rsp_valid pulse.

Structure
REQ-033 Package pll_apb_pkg SHALL hold the cmd_op encodings, the FSM state type, the lock-stable count (8) and the parameter defaults.
REQ-034 Sub-module pll_lock_sync SHALL implement the 2-flop synchroniser of lock.

Verification
REQ-035 WRITE addr 0x05 data 0x1234, apb_ready high on the 1st ACCESS cycle -> SETUP 1 cycle, ACCESS 1 cycle, rsp_valid 1 cycle later, rsp_err=0.
REQ-036 READ addr 0x1F, apb_ready after 3 ACCESS cycles, apb_rdata=0xBEEF -> sel/en/addr stable throughout, rsp_rdata=0xBEEF, rsp_err=0.
REQ-037 READ with apb_ready held 0 -> rsp_err=1 after 255 ACCESS cycles, then sel=en=0.
REQ-038 APPLY, lock rises 100 cycles after pll_rst falls -> pll_rst high exactly 16 cycles, rsp_err=0, and a lock glitch during the count restarts the stable count.
REQ-039 APPLY with LOCK_TIMEOUT=1000 and lock held 0 -> rsp_err=1 exactly at timeout.
REQ-040 rst asserted mid-ACCESS; cmd_valid while busy; cmd_op=11 -> respectively idle outputs with no rsp_valid; no accept; immediate rsp_err=1.
